// File: rtl/vga_timing_pkg.sv
// Display timing constants shared by the timing and draw stages.
// SVGA 800x600@60 defaults plus total-size helpers.
package vga_timing_pkg;

  localparam int CNT_W = 12;

  localparam int SVGA_H_VIS  = 800;
  localparam int SVGA_H_FP   = 40;
  localparam int SVGA_H_SYNC = 128;
  localparam int SVGA_H_BP   = 88;

  localparam int SVGA_V_VIS  = 600;
  localparam int SVGA_V_FP   = 1;
  localparam int SVGA_V_SYNC = 4;
  localparam int SVGA_V_BP   = 23;

  localparam int DISP_COLS = SVGA_H_VIS;
  localparam int DISP_ROWS = SVGA_V_VIS;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sync_t;

  function automatic int h_total(
    input int vis,
    input int fp,
    input int sw,
    input int bp
  );
    return vis + fp + sw + bp;
  endfunction

  function automatic int v_total(
    input int vis,
    input int fp,
    input int sw,
    input int bp
  );
    return vis + fp + sw + bp;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enabled shift register, DEPTH stages of WIDTH bits.
// DEPTH=0 collapses to a wire.
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en_i};
    assign q_o = d_i;
  end else begin : g_sr
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pong display timing stage: pixel counters, sync generation,
// and re-timing/blanking of the draw stage colour.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS   = SVGA_H_VIS,
  parameter int H_FP    = SVGA_H_FP,
  parameter int H_SYNC  = SVGA_H_SYNC,
  parameter int H_BP    = SVGA_H_BP,
  parameter int V_VIS   = SVGA_V_VIS,
  parameter int V_FP    = SVGA_V_FP,
  parameter int V_SYNC  = SVGA_V_SYNC,
  parameter int V_BP    = SVGA_V_BP,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int PIX_DIV = 1,
  parameter int RGB_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rgb_in,
  output logic [11:0] col_counter,
  output logic [11:0] row_counter,
  output logic        pix_en,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [7:0]  rgb_out
);

  localparam int H_TOTAL = h_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VIS, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
      PIX_DIV < 1 || RGB_LAT < 0) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_W = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_W = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

  logic             pix_en_q, pix_en_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             tick_q, tick_d;

  // pix_en is registered from the next divider value so it is
  // low in reset yet high in the same clk as div==PIX_DIV-1.
  if (PIX_DIV > 1) begin : g_div
    localparam int DW = $clog2(PIX_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    logic [DW-1:0] div_q, div_d;

    assign div_d    = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    assign pix_en_d = (div_d == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_q <= '0;
      else        div_q <= div_d;
    end
  end else begin : g_nodiv
    assign pix_en_d = 1'b1;
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    tick_d = 1'b0;
    if (pix_en_q) begin
      if (col_q == H_LAST) begin
        col_d  = '0;
        row_d  = (row_q == V_LAST) ? '0 : row_q + 12'd1;
        tick_d = (row_q == V_LAST);
      end else begin
        col_d = col_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      pix_en_q <= pix_en_d;
      col_q    <= col_d;
      row_q    <= row_d;
      tick_q   <= tick_d;
    end
  end

  sync_t dec_c, dly_q;

  assign dec_c.hs  = (col_q >= HS_LO) && (col_q <= HS_HI);
  assign dec_c.vs  = (row_q >= VS_LO) && (row_q <= VS_HI);
  assign dec_c.von = (col_q < H_VIS_W) && (row_q < V_VIS_W);

  sync_delay_line #(
    .DEPTH (RGB_LAT),
    .WIDTH ($bits(sync_t))
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_en_q),
    .d_i   (dec_c),
    .q_o   (dly_q)
  );

  logic       hs_q, vs_q, von_q;
  logic [7:0] rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      von_q <= 1'b0;
      rgb_q <= 8'h00;
    end else if (pix_en_q) begin
      hs_q  <= dly_q.hs ? HS_POL : ~HS_POL;
      vs_q  <= dly_q.vs ? VS_POL : ~VS_POL;
      von_q <= dly_q.von;
      rgb_q <= dly_q.von ? rgb_in : 8'h00;
    end
  end

  assign col_counter = col_q;
  assign row_counter = row_q;
  assign pix_en      = pix_en_q;
  assign frame_tick  = tick_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = von_q;
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-colour bench for vga_timing_gen on a reduced raster,
// checked each clk against a pixel-index reference model.
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 10, VF = 1, VS = 2, VB = 3;
  localparam int D   = 2;
  localparam int LAT = 2;
  localparam bit HP  = 1'b0;
  localparam bit VP  = 1'b1;
  localparam int HT    = HV + HF + HS + HB;
  localparam int VT    = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rgb_in = 8'h00;
  logic [11:0] col_counter, row_counter;
  logic        pix_en, frame_tick, hsync, vsync, video_on;
  logic [7:0]  rgb_out;

  vga_timing_gen #(
    .H_VIS (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_VIS (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL (HP), .VS_POL (VP),
    .PIX_DIV (D), .RGB_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rgb_in      (rgb_in),
    .col_counter (col_counter),
    .row_counter (row_counter),
    .pix_en      (pix_en),
    .frame_tick  (frame_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .rgb_out     (rgb_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // Model: k clks since release, P pixels advanced since release.
  int         k, P;
  bit         pe;
  bit         e_tick;
  logic [7:0] e_rgb;
  int         ticks_seen;

  function automatic bit hs_of(input int q);
    return q >= 0 && (q % HT) >= HV + HF && (q % HT) < HV + HF + HS;
  endfunction

  function automatic bit vs_of(input int q);
    int r;
    r = (q / HT) % VT;
    return q >= 0 && r >= VV + VF && r < VV + VF + VS;
  endfunction

  function automatic bit von_of(input int q);
    return q >= 0 && (q % HT) < HV && ((q / HT) % VT) < VV;
  endfunction

  task automatic model_reset();
    k      = 0;
    P      = 0;
    pe     = 1'b0;
    e_tick = 1'b0;
    e_rgb  = 8'h00;
  endtask

  task automatic model_edge();
    if (pe) begin
      e_rgb  = von_of(P - LAT) ? rgb_in : 8'h00;
      P      = P + 1;
      e_tick = (P % FRAME) == 0;
    end else begin
      e_tick = 1'b0;
    end
    k++;
    pe = (k % D) == D - 1;
  endtask

  task automatic check_all();
    int q;
    q = P - LAT - 1;
    chk("col", col_counter, P % HT);
    chk("row", row_counter, (P / HT) % VT);
    chk("pix_en", pix_en, pe);
    chk("frame_tick", frame_tick, e_tick);
    chk("hsync", hsync, hs_of(q) ? HP : !HP);
    chk("vsync", vsync, vs_of(q) ? VP : !VP);
    chk("video_on", video_on, von_of(q));
    chk("rgb_out", rgb_out, e_rgb);
    if (frame_tick === 1'b1) ticks_seen++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      rgb_in = 8'($urandom);
    end
  endtask

  initial begin
    bit found;
    model_reset();
    ticks_seen = 0;
    repeat (4) begin
      @(negedge clk);
      check_all();
      rgb_in = 8'($urandom);
    end
    rst_n = 1'b1;

    run(2 * FRAME * D + 100);
    chk("ticks_two_frames", ticks_seen, 2);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME * D && !found; i++) begin
      if (P % HT == 10 && (P / HT) % VT == 5) found = 1'b1;
      else run(1);
    end
    chk("mid_seek", found, 1'b1);

    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (3) begin
      @(negedge clk);
      check_all();
      rgb_in = 8'($urandom);
    end
    rst_n = 1'b1;
    ticks_seen = 0;

    run(FRAME * D + 20);
    chk("ticks_after_rst", ticks_seen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
